exception_unit: RTL
===================

# exception_unit

Commit-point exception arbiter that sits directly upstream of the CP0 block. It samples the memory-stage instruction's exception flags, synchronises external interrupt lines, and evaluates the interrupt condition against CP0 Status/Cause. Each cycle it picks at most one highest-priority event and drives the CP0 exception record (`exception_t` / `is_eret`). It then holds a pipeline flush and a fetch redirect until fetch accepts the new PC.

## Interface
- `RESET_VEC`, default `32'hbfc0_0380`: exception vector used when Status.BEV=1.
- `NORMAL_VEC`, default `32'h8000_0180`: exception vector used when Status.BEV=0.
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: memory-stage instruction is present.
- `commit_ready` out 1: the unit accepts a commit this cycle.
- `pc` in 32: PC of the committing instruction.
- `in_delay_slot` in 1: the committing instruction is in a branch delay slot.
- `f_adel` in 1: instruction-fetch address error; badvaddr is `pc`.
- `f_ri` in 1: reserved instruction.
- `f_sys` in 1: SYSCALL.
- `f_bp` in 1: BREAK.
- `f_ov` in 1: arithmetic overflow.
- `f_ld_adel` in 1: load address error.
- `f_st_ades` in 1: store address error.
- `f_eret` in 1: the instruction is ERET.
- `data_addr` in 32: load/store effective address.
- `ext_int` in 6: asynchronous hardware interrupt lines.
- `timer_interrupt` in 1: timer interrupt from CP0.
- `status_ie` in 1, `status_exl` in 1, `status_erl` in 1, `status_bev` in 1, `status_im` in 8: CP0 Status fields.
- `cause_ip_sw` in 2: CP0 Cause.IP[1:0].
- `epc` in 32: CP0 EPC.
- `exception_info` out `exception_t`: fields valid, code[4:0], pc, in_delay_slot, badvaddr, location.
- `is_eret` out 1: ERET commit pulse to CP0.
- `flush` out 1: kill every younger pipeline stage.
- `redirect_valid` out 1: redirect request to fetch.
- `redirect_ready` in 1: fetch accepts the redirect.
- `redirect_pc` out 32: new fetch PC.

## Operation
- Interrupt lines: `ext_int` passes through a 2-flop synchroniser.
- IP[7] = sync[5] | `timer_interrupt`; IP[6:2] = sync[4:0]; IP[1:0] = `cause_ip_sw`.
- int_pending = IE & ~EXL & ~ERL & |(IP & IM).
- Commit: a commit occurs when `instr_valid` & `commit_ready`. The event is the highest-priority item in this order:
  - interrupt (code 0x00)
  - f_adel (0x04; badvaddr = `pc`)
  - f_ri (0x0a)
  - f_sys (0x08)
  - f_bp (0x09)
  - f_ov (0x0c)
  - f_ld_adel (0x04; badvaddr = `data_addr`)
  - f_st_ades (0x05; badvaddr = `data_addr`)
  - f_eret
- An interrupt is taken only on a valid commit. With no valid instruction it stays pending.
- An interrupt or any exception beats `f_eret`: `is_eret` is not raised.
- A commit with no event passes through; the FSM stays in IDLE.
- FSM states: IDLE and REDIRECT.
  - IDLE -> REDIRECT on a commit that carries an event.
  - REDIRECT -> IDLE on `redirect_valid` & `redirect_ready`.
- Registered event record:
  - code, pc, in_delay_slot and badvaddr are latched at commit.
  - location = `status_bev` ? RESET_VEC : NORMAL_VEC.
  - `redirect_pc` = location for an exception, or `epc` (sampled at commit) for ERET.
- `commit_ready` = (state == IDLE). Commits are blocked for the whole of REDIRECT.

## Timing
- Reset values (asynchronous): state IDLE; synchroniser flops 0; `exception_info` all-zero; `is_eret` 0; `flush` 0; `redirect_valid` 0; `redirect_pc` 0; `commit_ready` 1.
- Commit with event in cycle T:
  - T+1: `exception_info.valid` or `is_eret` is high for exactly one cycle.
  - `flush` and `redirect_valid` are high from T+1 until the handshake cycle, inclusive.
  - `redirect_pc` is stable for the whole REDIRECT period.
- `redirect_ready` already high at T+1: handshake at T+1, IDLE at T+2, `commit_ready`=1 at T+2.
- `ext_int` rising edge: visible in int_pending 2 cycles later.
- `status_*` and `cause_ip_sw` are used combinationally in the commit cycle. A CP0 update caused by the event is visible from T+2.
- Reset asserted during REDIRECT: outputs return to reset values immediately; no redirect completes.

## Structure
- `exception_pkg` holds:
  - the `CODE_INT`, `CODE_ADEL`, `CODE_ADES`, `CODE_SYS`, `CODE_BP`, `CODE_RI`, `CODE_OV` localparams
  - the `exception_t` struct
  - the two-state FSM enum
- Sub-module `int_sync`: parameterised-width 2-flop synchroniser, asynchronous active-low reset.
- Priority encoder, FSM and output registers live in `exception_unit`.

## Test plan
- f_ov commit, pc=0x80001000, not in delay slot, BEV=0:
  - T+1: valid=1, code=0x0c, location=0x80000180, flush=1, redirect_pc=0x80000180.
  - `redirect_ready` held low 3 cycles: flush and redirect_valid stay high 4 cycles; `commit_ready`=0 throughout.
- f_ld_adel, data_addr=0x80000003, delay slot: code=0x04, badvaddr=0x80000003, in_delay_slot=1.
- f_adel together with f_st_ades: code=0x04, badvaddr=`pc`.
- ext_int[2] pulse with IE=1, IM[4]=1, EXL=0:
  - no `instr_valid` for 5 cycles: no event.
  - first valid commit with f_sys=1: code=0x00.
  - repeat with EXL=1: code=0x08.
- f_eret, epc=0x80002000: T+1 is_eret=1, valid=0, redirect_pc=0x80002000.
- Reset asserted mid-REDIRECT: flush=0, redirect_valid=0, commit_ready=1 immediately; next event handled normally.

Source files
------------

// File: rtl/exception_pkg.sv
// Shared types for the commit-point exception arbiter: cause codes, CP0 record and FSM states.
package exception_pkg;

  localparam logic [4:0] CODE_INT  = 5'h00;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BP   = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0a;
  localparam logic [4:0] CODE_OV   = 5'h0c;

  typedef struct packed {
    logic        valid;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        in_delay_slot;
    logic [31:0] badvaddr;
    logic [31:0] location;
  } exception_t;

  typedef enum logic {
    ST_IDLE,
    ST_REDIRECT
  } state_e;

endpackage

// File: rtl/exception_unit_if.sv
// CP0 record plus fetch-redirect handshake between the exception unit and its consumers.
interface exception_unit_if;
  import exception_pkg::*;

  exception_t  exception_info;
  logic        is_eret;
  logic        flush;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;

  modport master (
    output exception_info,
    output is_eret,
    output flush,
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  exception_info,
    input  is_eret,
    input  flush,
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/int_sync.sv
// Parameterised two-flop synchroniser for asynchronous level inputs.
module int_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/exception_unit.sv
// Commit-point exception arbiter: picks the highest-priority event per commit, drives the
// CP0 record and holds flush/redirect until fetch accepts the new PC.
module exception_unit
  import exception_pkg::*;
#(
  parameter logic [31:0] RESET_VEC  = 32'hbfc0_0380,
  parameter logic [31:0] NORMAL_VEC = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        instr_valid,
  output logic        commit_ready,
  input  logic [31:0] pc,
  input  logic        in_delay_slot,
  input  logic        f_adel,
  input  logic        f_ri,
  input  logic        f_sys,
  input  logic        f_bp,
  input  logic        f_ov,
  input  logic        f_ld_adel,
  input  logic        f_st_ades,
  input  logic        f_eret,
  input  logic [31:0] data_addr,
  input  logic [5:0]  ext_int,
  input  logic        timer_interrupt,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic        status_erl,
  input  logic        status_bev,
  input  logic [7:0]  status_im,
  input  logic [1:0]  cause_ip_sw,
  input  logic [31:0] epc,
  exception_unit_if.master cp0
);

  logic [5:0]  ext_int_sync;
  logic [7:0]  ip;
  logic        int_pending;
  logic        commit;
  logic [31:0] location;

  logic        evt_valid;
  logic        evt_eret;
  logic [4:0]  evt_code;
  logic [31:0] evt_badvaddr;

  state_e      state_q;
  exception_t  info_q;
  logic        is_eret_q;
  logic        flush_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  int_sync #(.WIDTH(6)) u_int_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d_i   (ext_int),
    .q_o   (ext_int_sync)
  );

  assign ip          = {ext_int_sync[5] | timer_interrupt, ext_int_sync[4:0], cause_ip_sw};
  assign int_pending = status_ie & ~status_exl & ~status_erl & (|(ip & status_im));

  assign commit_ready = (state_q == ST_IDLE);
  assign commit       = instr_valid & commit_ready;
  assign location     = status_bev ? RESET_VEC : NORMAL_VEC;

  // Fixed priority: interrupt first, then fetch-side faults, then execute/memory faults, ERET last.
  always_comb begin
    evt_valid    = 1'b0;
    evt_eret     = 1'b0;
    evt_code     = CODE_INT;
    evt_badvaddr = '0;
    if (int_pending) begin
      evt_valid = 1'b1;
    end else if (f_adel) begin
      evt_valid    = 1'b1;
      evt_code     = CODE_ADEL;
      evt_badvaddr = pc;
    end else if (f_ri) begin
      evt_valid = 1'b1;
      evt_code  = CODE_RI;
    end else if (f_sys) begin
      evt_valid = 1'b1;
      evt_code  = CODE_SYS;
    end else if (f_bp) begin
      evt_valid = 1'b1;
      evt_code  = CODE_BP;
    end else if (f_ov) begin
      evt_valid = 1'b1;
      evt_code  = CODE_OV;
    end else if (f_ld_adel) begin
      evt_valid    = 1'b1;
      evt_code     = CODE_ADEL;
      evt_badvaddr = data_addr;
    end else if (f_st_ades) begin
      evt_valid    = 1'b1;
      evt_code     = CODE_ADES;
      evt_badvaddr = data_addr;
    end else if (f_eret) begin
      evt_valid = 1'b1;
      evt_eret  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= ST_IDLE;
      info_q           <= '0;
      is_eret_q        <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      // Record fields persist; only the valid/eret strobes are single-cycle.
      info_q.valid <= 1'b0;
      is_eret_q    <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (commit && evt_valid) begin
            state_q                <= ST_REDIRECT;
            info_q.valid           <= ~evt_eret;
            info_q.code            <= evt_code;
            info_q.pc              <= pc;
            info_q.in_delay_slot   <= in_delay_slot;
            info_q.badvaddr        <= evt_badvaddr;
            info_q.location        <= location;
            is_eret_q              <= evt_eret;
            flush_q                <= 1'b1;
            redirect_valid_q       <= 1'b1;
            redirect_pc_q          <= evt_eret ? epc : location;
          end
        end
        ST_REDIRECT: begin
          if (redirect_valid_q && cp0.redirect_ready) begin
            state_q          <= ST_IDLE;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign cp0.exception_info = info_q;
  assign cp0.is_eret        = is_eret_q;
  assign cp0.flush          = flush_q;
  assign cp0.redirect_valid = redirect_valid_q;
  assign cp0.redirect_pc    = redirect_pc_q;

endmodule
